disp_scan_ctrl: RTL

- Time-multiplexed scan controller for the 4-digit, common-anode 7-segment display that shows the selected PWM frequency.
- Takes the four digit codes from the frequency decoder (n3..n0; 0-9 = numeral, 10 = decimal point, 11-15 = blank).
- Sequences one digit at a time with a dead-time gap, blanks leading zeros, and latches the digit codes only at frame boundaries so the display never tears.

---
 rtl/disp_scan_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/disp_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with per-slot dead time,
// leading-zero blanking and frame-coherent capture of the digit codes.
module disp_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] n_0f,
    input  logic [3:0] n_1f,
    input  logic [3:0] n_2f,
    input  logic [3:0] n_3f,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int                CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]     CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]     BLANK_END = CW'(BLANK_CYC);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_digit;
    logic [3:0][3:0] r_sh;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp;
    logic            r_frame_tick;

    logic [3:0]      w_blank;
    logic [3:0]      w_code;
    logic [6:0]      w_seg;
    logic            w_dp;
    logic [3:0]      w_an;

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

    // Outputs are decoded from the current slot state and registered, so they
    // trail the counter by one cycle; frame_tick is aligned the same way.
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = (r_sh[3] == 4'd0);
        w_blank[2] = w_blank[3] && (r_sh[2] == 4'd0);
        w_blank[1] = w_blank[2] && (r_sh[1] == 4'd0);
        w_code     = r_sh[r_digit];
        w_seg      = 7'b1111111;
        w_dp       = 1'b1;
        if (!w_blank[r_digit]) begin
            case (w_code)
                4'd0:    w_seg = 7'b1000000;
                4'd1:    w_seg = 7'b1111001;
                4'd2:    w_seg = 7'b0100100;
                4'd3:    w_seg = 7'b0110000;
                4'd4:    w_seg = 7'b0011001;
                4'd5:    w_seg = 7'b0010010;
                4'd6:    w_seg = 7'b0000010;
                4'd7:    w_seg = 7'b1111000;
                4'd8:    w_seg = 7'b0000000;
                4'd9:    w_seg = 7'b0010000;
                4'd10:   w_dp  = 1'b0;
                default: w_seg = 7'b1111111;
            endcase
        end
        w_an          = 4'b1111;
        w_an[r_digit] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_digit      <= 2'd0;
            r_sh         <= '0;
            r_an         <= 4'b1111;
            r_seg        <= 7'b1111111;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_an         <= 4'b1111;
                    r_seg        <= 7'b1111111;
                    r_dp         <= 1'b1;
                    r_frame_tick <= 1'b0;
                    if (enable) begin
                        r_state <= SCAN;
                        r_cnt   <= '0;
                        r_digit <= 2'd0;
                        r_sh    <= {n_3f, n_2f, n_1f, n_0f};
                    end
                end
                default: begin
                    if (!enable) begin
                        r_state      <= IDLE;
                        r_cnt        <= '0;
                        r_digit      <= 2'd0;
                        r_an         <= 4'b1111;
                        r_seg        <= 7'b1111111;
                        r_dp         <= 1'b1;
                        r_frame_tick <= 1'b0;
                    end else begin
                        if (r_cnt < BLANK_END) begin
                            r_an  <= 4'b1111;
                            r_seg <= 7'b1111111;
                            r_dp  <= 1'b1;
                        end else begin
                            r_an  <= w_an;
                            r_seg <= w_seg;
                            r_dp  <= w_dp;
                        end
                        r_frame_tick <= (r_digit == 2'd3) && (r_cnt == CNT_MAX);
                        if (r_cnt == CNT_MAX) begin
                            r_cnt   <= '0;
                            r_digit <= r_digit + 2'd1;
                            // Recapture only at the frame boundary to avoid tearing.
                            if (r_digit == 2'd3)
                                r_sh <= {n_3f, n_2f, n_1f, n_0f};
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
